int_issue_queue: RTL and testbench

- Integer reservation station sitting directly upstream of int_alu.
- Holds dispatched integer instructions until their GPR source operands and T-bit source are ready, then issues the oldest ready entry, one per cycle.
- Issue outputs drive the physical register file read, which is combinational on the issue tags, and the int_alu issue_en/issue_inst inputs.
- Wakeup comes from snooping the CDB packet.

---
 rtl/int_issue_queue_pkg.sv | 53 +++++
 rtl/iq_wakeup.sv | 25 ++
 rtl/int_issue_queue.sv | 150 +++++++++++++++
 tb/tb_int_issue_queue.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_issue_queue_pkg.sv
// Shared types for the integer issue queue: renamed instruction, CDB packet and queue entry.
package int_issue_queue_pkg;

    localparam int IQ_DEPTH = 8;
    localparam int TAG_W    = 6;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_ADDI = 4'd2,
        OP_ADDC = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_SHL  = 4'd7
    } Op_t;

    typedef struct packed {
        Op_t              op;
        logic [TAG_W-1:0] p_rd;
        logic [TAG_W-1:0] p_t;
        logic             use_imm;
        logic             read_t;
        logic             write_t;
        logic [15:0]      imm;
    } Inst_t;

    typedef struct packed {
        logic             en;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             t_en;
        logic [TAG_W-1:0] t_tag;
        logic             t_val;
        logic             exc;
    } Cdb_pkt_t;

    typedef struct packed {
        Inst_t            inst;
        logic [TAG_W-1:0] tag_a;
        logic [TAG_W-1:0] tag_b;
        logic [TAG_W-1:0] tag_t;
        logic             rdy_a;
        logic             rdy_b;
        logic             rdy_t;
        logic             valid;
    } Iq_entry_t;

    function automatic logic entry_ready(input Iq_entry_t e);
        return e.valid & e.rdy_a & e.rdy_b & e.rdy_t;
    endfunction

endpackage

// File: rtl/iq_wakeup.sv
// CDB snoop for one queue slot: turns current ready bits plus a broadcast into next ready bits.
module iq_wakeup
    import int_issue_queue_pkg::*;
(
    input  logic [TAG_W-1:0] tag_a,
    input  logic [TAG_W-1:0] tag_b,
    input  logic [TAG_W-1:0] tag_t,
    input  logic             rdy_a,
    input  logic             rdy_b,
    input  logic             rdy_t,
    input  Cdb_pkt_t         cdb_pkt,
    output logic             nxt_rdy_a,
    output logic             nxt_rdy_b,
    output logic             nxt_rdy_t
);

    // Exceptions still produce a valid tag, so exc never blocks a wakeup.
    logic unused_cdb;
    assign unused_cdb = ^{cdb_pkt.data, cdb_pkt.t_val, cdb_pkt.exc};

    assign nxt_rdy_a = rdy_a | (cdb_pkt.en   && (tag_a == cdb_pkt.tag));
    assign nxt_rdy_b = rdy_b | (cdb_pkt.en   && (tag_b == cdb_pkt.tag));
    assign nxt_rdy_t = rdy_t | (cdb_pkt.t_en && (tag_t == cdb_pkt.t_tag));

endmodule

// File: rtl/int_issue_queue.sv
// Integer reservation station: compacting age-ordered queue, oldest-ready select, CDB wakeup.
module int_issue_queue
    import int_issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int TAG_W = int_issue_queue_pkg::TAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       recovery_en,
    input  logic                       disp_valid,
    input  Inst_t                      disp_inst,
    input  logic [TAG_W-1:0]           disp_tag_a,
    input  logic [TAG_W-1:0]           disp_tag_b,
    input  logic [TAG_W-1:0]           disp_tag_t,
    input  logic                       disp_rdy_a,
    input  logic                       disp_rdy_b,
    input  logic                       disp_rdy_t,
    output logic                       disp_ready,
    input  Cdb_pkt_t                   cdb_pkt,
    output logic                       issue_en,
    output Inst_t                      issue_inst,
    output logic [TAG_W-1:0]           issue_tag_a,
    output logic [TAG_W-1:0]           issue_tag_b,
    output logic [TAG_W-1:0]           issue_tag_t,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    Iq_entry_t        entries     [DEPTH];
    Iq_entry_t        nxt_entries [DEPTH];
    Iq_entry_t        shift_src   [DEPTH+1];
    Iq_entry_t        disp_entry;

    logic [DEPTH-1:0] wake_a, wake_b, wake_t;
    logic             disp_wake_a, disp_wake_b, disp_wake_t;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    Inst_t            sel_inst;
    logic [TAG_W-1:0] sel_tag_a, sel_tag_b, sel_tag_t;

    logic             do_disp;
    logic [CNT_W-1:0] wr_idx;

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        iq_wakeup u_wake (
            .tag_a     (entries[g].tag_a),
            .tag_b     (entries[g].tag_b),
            .tag_t     (entries[g].tag_t),
            .rdy_a     (entries[g].rdy_a),
            .rdy_b     (entries[g].rdy_b),
            .rdy_t     (entries[g].rdy_t),
            .cdb_pkt   (cdb_pkt),
            .nxt_rdy_a (wake_a[g]),
            .nxt_rdy_b (wake_b[g]),
            .nxt_rdy_t (wake_t[g])
        );
    end

    // Immediate operands and instructions that never read T count as ready at capture.
    iq_wakeup u_disp_wake (
        .tag_a     (disp_tag_a),
        .tag_b     (disp_tag_b),
        .tag_t     (disp_tag_t),
        .rdy_a     (disp_rdy_a),
        .rdy_b     (disp_rdy_b | disp_inst.use_imm),
        .rdy_t     (disp_rdy_t | ~disp_inst.read_t),
        .cdb_pkt   (cdb_pkt),
        .nxt_rdy_a (disp_wake_a),
        .nxt_rdy_b (disp_wake_b),
        .nxt_rdy_t (disp_wake_t)
    );

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_inst  = '0;
        sel_tag_a = '0;
        sel_tag_b = '0;
        sel_tag_t = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && entry_ready(entries[i])) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_inst  = entries[i].inst;
                sel_tag_a = entries[i].tag_a;
                sel_tag_b = entries[i].tag_b;
                sel_tag_t = entries[i].tag_t;
            end
        end
    end

    assign issue_en    = sel_found & ~recovery_en & ~rst;
    assign issue_inst  = issue_en ? sel_inst  : '0;
    assign issue_tag_a = issue_en ? sel_tag_a : '0;
    assign issue_tag_b = issue_en ? sel_tag_b : '0;
    assign issue_tag_t = issue_en ? sel_tag_t : '0;

    // Slots freed by this cycle's issue are not offered to dispatch until next cycle.
    assign disp_ready = (count < CNT_W'(DEPTH));
    assign do_disp    = disp_valid & disp_ready;
    assign wr_idx     = count - CNT_W'(issue_en);

    always_comb begin
        disp_entry       = '0;
        disp_entry.inst  = disp_inst;
        disp_entry.tag_a = disp_tag_a;
        disp_entry.tag_b = disp_tag_b;
        disp_entry.tag_t = disp_tag_t;
        disp_entry.rdy_a = disp_wake_a;
        disp_entry.rdy_b = disp_wake_b;
        disp_entry.rdy_t = disp_wake_t;
        disp_entry.valid = 1'b1;
    end

    // Entries above the issued slot slide down one place, carrying this cycle's wakeup.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            shift_src[i]       = entries[i];
            shift_src[i].rdy_a = wake_a[i];
            shift_src[i].rdy_b = wake_b[i];
            shift_src[i].rdy_t = wake_t[i];
        end
        shift_src[DEPTH] = '0;

        for (int i = 0; i < DEPTH; i++) begin
            nxt_entries[i] = shift_src[i];
            if (issue_en && (IDX_W'(i) >= sel_idx)) begin
                nxt_entries[i] = shift_src[i+1];
            end
            if (do_disp && (CNT_W'(i) == wr_idx)) begin
                nxt_entries[i] = disp_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || recovery_en) begin
            entries <= '{default: '0};
            count   <= '0;
        end else begin
            entries <= nxt_entries;
            count   <= count + CNT_W'(do_disp) - CNT_W'(issue_en);
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// Self-checking bench for int_issue_queue against an age-ordered list model of the station.
module tb_int_issue_queue;
    import int_issue_queue_pkg::*;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       recovery_en;
    logic       disp_valid;
    Inst_t      disp_inst;
    logic [5:0] disp_tag_a, disp_tag_b, disp_tag_t;
    logic       disp_rdy_a, disp_rdy_b, disp_rdy_t;
    logic       disp_ready;
    Cdb_pkt_t   cdb_pkt;
    logic       issue_en;
    Inst_t      issue_inst;
    logic [5:0] issue_tag_a, issue_tag_b, issue_tag_t;
    logic [3:0] count;

    int total = 0;
    int bad   = 0;

    int_issue_queue #(.DEPTH(DEPTH), .TAG_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .recovery_en (recovery_en),
        .disp_valid  (disp_valid),
        .disp_inst   (disp_inst),
        .disp_tag_a  (disp_tag_a),
        .disp_tag_b  (disp_tag_b),
        .disp_tag_t  (disp_tag_t),
        .disp_rdy_a  (disp_rdy_a),
        .disp_rdy_b  (disp_rdy_b),
        .disp_rdy_t  (disp_rdy_t),
        .disp_ready  (disp_ready),
        .cdb_pkt     (cdb_pkt),
        .issue_en    (issue_en),
        .issue_inst  (issue_inst),
        .issue_tag_a (issue_tag_a),
        .issue_tag_b (issue_tag_b),
        .issue_tag_t (issue_tag_t),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: oldest first; an instruction issues once all three sources are known ready.
    typedef struct {
        Inst_t      inst;
        logic [5:0] ta, tb, tt;
        bit         ra, rb, rt;
    } ment_t;

    ment_t      q[$];
    ment_t      qn[$];
    logic       exp_en;
    Inst_t      exp_inst;
    logic [5:0] exp_ta, exp_tb, exp_tt;
    logic       exp_ready;
    logic [3:0] exp_count;

    function automatic bit woke_gpr(input logic [5:0] tag);
        return cdb_pkt.en && (tag == cdb_pkt.tag);
    endfunction

    function automatic bit woke_t(input logic [5:0] tag);
        return cdb_pkt.t_en && (tag == cdb_pkt.t_tag);
    endfunction

    function automatic Inst_t mk_inst(input Op_t op, input logic use_imm, input logic read_t, input logic [5:0] p_rd);
        Inst_t x;
        x         = '0;
        x.op      = op;
        x.p_rd    = p_rd;
        x.p_t     = 6'd1;
        x.use_imm = use_imm;
        x.read_t  = read_t;
        x.imm     = {10'd0, p_rd};
        return x;
    endfunction

    task automatic idle();
        recovery_en = 1'b0;
        disp_valid  = 1'b0;
        disp_inst   = '0;
        disp_tag_a  = '0;
        disp_tag_b  = '0;
        disp_tag_t  = '0;
        disp_rdy_a  = 1'b0;
        disp_rdy_b  = 1'b0;
        disp_rdy_t  = 1'b0;
        cdb_pkt     = '0;
    endtask

    task automatic dispatch(input Inst_t inst, input logic [5:0] ta, input logic [5:0] tb, input logic [5:0] tt,
                            input logic ra, input logic rb, input logic rt);
        disp_valid = 1'b1;
        disp_inst  = inst;
        disp_tag_a = ta;
        disp_tag_b = tb;
        disp_tag_t = tt;
        disp_rdy_a = ra;
        disp_rdy_b = rb;
        disp_rdy_t = rt;
    endtask

    // Lets the inputs settle, then derives expected outputs and the model's next contents.
    task automatic settle();
        int    sel;
        ment_t e;
        #1;
        sel = -1;
        foreach (q[i]) if (sel < 0 && q[i].ra && q[i].rb && q[i].rt) sel = i;
        exp_en    = (sel >= 0) && !recovery_en && !rst;
        exp_inst  = '0;
        exp_ta    = '0;
        exp_tb    = '0;
        exp_tt    = '0;
        if (exp_en) begin
            exp_inst = q[sel].inst;
            exp_ta   = q[sel].ta;
            exp_tb   = q[sel].tb;
            exp_tt   = q[sel].tt;
        end
        exp_ready = (q.size() < DEPTH);
        exp_count = 4'(q.size());
        qn = {};
        if (!(rst || recovery_en)) begin
            foreach (q[i]) begin
                e    = q[i];
                e.ra = e.ra | woke_gpr(e.ta);
                e.rb = e.rb | woke_gpr(e.tb);
                e.rt = e.rt | woke_t(e.tt);
                if (!(exp_en && i == sel)) qn.push_back(e);
            end
            if (disp_valid && q.size() < DEPTH) begin
                e.inst = disp_inst;
                e.ta   = disp_tag_a;
                e.tb   = disp_tag_b;
                e.tt   = disp_tag_t;
                e.ra   = disp_rdy_a | woke_gpr(disp_tag_a);
                e.rb   = disp_rdy_b | disp_inst.use_imm | woke_gpr(disp_tag_b);
                e.rt   = disp_rdy_t | !disp_inst.read_t | woke_t(disp_tag_t);
                qn.push_back(e);
            end
        end
    endtask

    task automatic tick();
        q = qn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        dispatch(mk_inst(OP_ADD, 1'b0, 1'b0, 6'd9), 6'd1, 6'd2, 6'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            settle();
            tick();
        end
        rst = 1'b0;
        idle();
        settle();
        total++; if (issue_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_issue_en: got %0b want 0", issue_en); end
        total++; if (issue_inst !== Inst_t'(0)) begin bad++; $display("[TB] FAIL reset_issue_inst: got %0h want 0", issue_inst); end
        total++; if ({issue_tag_a, issue_tag_b, issue_tag_t} !== 18'd0) begin bad++; $display("[TB] FAIL reset_tags: got %0h want 0", {issue_tag_a, issue_tag_b, issue_tag_t}); end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_disp_ready: got %0b want 1", disp_ready); end
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        tick();
    endtask

    task automatic test_basic_issue();
        Inst_t add_i;
        add_i = mk_inst(OP_ADD, 1'b0, 1'b0, 6'd10);
        idle();
        dispatch(add_i, 6'd1, 6'd2, 6'd0, 1'b1, 1'b1, 1'b0);
        settle();
        total++; if (issue_en !== 1'b0) begin bad++; $display("[TB] FAIL basic_no_bypass: got %0b want 0", issue_en); end
        tick();
        idle();
        settle();
        total++; if (issue_en !== 1'b1) begin bad++; $display("[TB] FAIL basic_issue_en: got %0b want 1", issue_en); end
        total++; if (issue_inst !== add_i) begin bad++; $display("[TB] FAIL basic_issue_inst: got %0h want %0h", issue_inst, add_i); end
        total++; if (count !== 4'd1) begin bad++; $display("[TB] FAIL basic_count_1: got %0d want 1", count); end
        tick();
        settle();
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL basic_count_0: got %0d want 0", count); end
        tick();
    endtask

    task automatic test_age_order();
        idle();
        dispatch(mk_inst(OP_ADD, 1'b0, 1'b0, 6'd11), 6'd5, 6'd2, 6'd0, 1'b0, 1'b1, 1'b0);
        settle();
        tick();
        dispatch(mk_inst(OP_SUB, 1'b0, 1'b0, 6'd12), 6'd3, 6'd4, 6'd0, 1'b1, 1'b1, 1'b0);
        settle();
        tick();
        idle();
        settle();
        total++; if (issue_en !== 1'b1 || issue_inst.op !== OP_SUB) begin bad++; $display("[TB] FAIL age_sub_first: got en=%0b op=%0d want en=1 op=%0d", issue_en, issue_inst.op, OP_SUB); end
        tick();
        cdb_pkt.en  = 1'b1;
        cdb_pkt.tag = 6'd5;
        settle();
        total++; if (issue_en !== 1'b0) begin bad++; $display("[TB] FAIL age_wake_registered: got %0b want 0", issue_en); end
        tick();
        idle();
        settle();
        total++; if (issue_en !== 1'b1 || issue_inst.op !== OP_ADD || issue_tag_a !== 6'd5) begin bad++; $display("[TB] FAIL age_add_after_wake: got en=%0b op=%0d ta=%0d want en=1 op=%0d ta=5", issue_en, issue_inst.op, issue_tag_a, OP_ADD); end
        tick();
    endtask

    task automatic test_imm();
        idle();
        dispatch(mk_inst(OP_ADDI, 1'b1, 1'b0, 6'd13), 6'd7, 6'd9, 6'd0, 1'b1, 1'b0, 1'b0);
        settle();
        tick();
        idle();
        settle();
        total++; if (issue_en !== 1'b1 || issue_inst.op !== OP_ADDI) begin bad++; $display("[TB] FAIL imm_issue: got en=%0b op=%0d want en=1 op=%0d", issue_en, issue_inst.op, OP_ADDI); end
        tick();
    endtask

    task automatic test_t_wakeup();
        idle();
        dispatch(mk_inst(OP_ADDC, 1'b0, 1'b1, 6'd14), 6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 1'b0);
        settle();
        tick();
        idle();
        cdb_pkt.en  = 1'b1;
        cdb_pkt.tag = 6'd3;
        settle();
        tick();
        idle();
        cdb_pkt.t_en  = 1'b1;
        cdb_pkt.t_tag = 6'd3;
        settle();
        total++; if (issue_en !== 1'b0) begin bad++; $display("[TB] FAIL t_gpr_cdb_ignored: got %0b want 0", issue_en); end
        tick();
        idle();
        settle();
        total++; if (issue_en !== 1'b1 || issue_inst.op !== OP_ADDC || issue_tag_t !== 6'd3) begin bad++; $display("[TB] FAIL t_wake_issue: got en=%0b op=%0d tt=%0d want en=1 op=%0d tt=3", issue_en, issue_inst.op, issue_tag_t, OP_ADDC); end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            dispatch(mk_inst(OP_AND, 1'b0, 1'b0, 6'(32 + i)), 6'(10 + i), 6'd2, 6'd0, 1'b0, 1'b1, 1'b0);
            settle();
            tick();
        end
        idle();
        dispatch(mk_inst(OP_SUB, 1'b0, 1'b0, 6'd50), 6'd1, 6'd2, 6'd0, 1'b1, 1'b1, 1'b1);
        settle();
        total++; if (count !== 4'd8 || disp_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_flags: got count=%0d rdy=%0b want count=8 rdy=0", count, disp_ready); end
        tick();
        idle();
        cdb_pkt.en  = 1'b1;
        cdb_pkt.tag = 6'd12;
        settle();
        total++; if (count !== 4'd8 || issue_en !== 1'b0) begin bad++; $display("[TB] FAIL full_drop: got count=%0d en=%0b want count=8 en=0", count, issue_en); end
        tick();
        idle();
        settle();
        total++; if (issue_en !== 1'b1 || issue_tag_a !== 6'd12 || disp_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_wake_mid: got en=%0b ta=%0d rdy=%0b want en=1 ta=12 rdy=0", issue_en, issue_tag_a, disp_ready); end
        tick();
        cdb_pkt.en  = 1'b1;
        cdb_pkt.tag = 6'd13;
        settle();
        total++; if (count !== 4'd7 || disp_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_after_issue: got count=%0d rdy=%0b want count=7 rdy=1", count, disp_ready); end
        tick();
        idle();
        settle();
        total++; if (issue_en !== 1'b1 || issue_inst.p_rd !== 6'd35) begin bad++; $display("[TB] FAIL full_shifted: got en=%0b p_rd=%0d want en=1 p_rd=35", issue_en, issue_inst.p_rd); end
        tick();
        recovery_en = 1'b1;
        settle();
        tick();
    endtask

    task automatic test_recovery();
        logic [5:0] tags [5];
        tags = '{6'd20, 6'd21, 6'd22, 6'd21, 6'd23};
        for (int i = 0; i < 5; i++) begin
            idle();
            dispatch(mk_inst(OP_OR, 1'b0, 1'b0, 6'(40 + i)), tags[i], 6'd2, 6'd0, 1'b0, 1'b1, 1'b0);
            settle();
            tick();
        end
        idle();
        cdb_pkt.en  = 1'b1;
        cdb_pkt.tag = 6'd21;
        settle();
        tick();
        idle();
        recovery_en = 1'b1;
        dispatch(mk_inst(OP_XOR, 1'b0, 1'b0, 6'd60), 6'd1, 6'd2, 6'd0, 1'b1, 1'b1, 1'b1);
        settle();
        total++; if (count !== 4'd5 || issue_en !== 1'b0) begin bad++; $display("[TB] FAIL recov_suppress: got count=%0d en=%0b want count=5 en=0", count, issue_en); end
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            settle();
            total++; if (count !== 4'd0 || issue_en !== 1'b0) begin bad++; $display("[TB] FAIL recov_empty: got count=%0d en=%0b want count=0 en=0", count, issue_en); end
            tick();
        end
    endtask

    task automatic test_random();
        Inst_t ri;
        for (int n = 0; n < 400; n++) begin
            idle();
            recovery_en = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) != 0) begin
                ri = mk_inst(Op_t'(4'($urandom_range(0, 7))), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
                dispatch(ri, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            cdb_pkt.en    = 1'($urandom_range(0, 1));
            cdb_pkt.tag   = 6'($urandom_range(0, 7));
            cdb_pkt.data  = $urandom;
            cdb_pkt.t_en  = 1'($urandom_range(0, 1));
            cdb_pkt.t_tag = 6'($urandom_range(0, 7));
            cdb_pkt.exc   = 1'($urandom_range(0, 1));
            settle();
            total++; if (issue_en !== exp_en) begin bad++; $display("[TB] FAIL rnd_issue_en @%0d: got %0b want %0b", n, issue_en, exp_en); end
            total++; if (issue_inst !== exp_inst) begin bad++; $display("[TB] FAIL rnd_issue_inst @%0d: got %0h want %0h", n, issue_inst, exp_inst); end
            total++; if ({issue_tag_a, issue_tag_b, issue_tag_t} !== {exp_ta, exp_tb, exp_tt}) begin bad++; $display("[TB] FAIL rnd_tags @%0d: got %0h want %0h", n, {issue_tag_a, issue_tag_b, issue_tag_t}, {exp_ta, exp_tb, exp_tt}); end
            total++; if (disp_ready !== exp_ready) begin bad++; $display("[TB] FAIL rnd_disp_ready @%0d: got %0b want %0b", n, disp_ready, exp_ready); end
            total++; if (count !== exp_count) begin bad++; $display("[TB] FAIL rnd_count @%0d: got %0d want %0d", n, count, exp_count); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_basic_issue();
        test_age_order();
        test_imm();
        test_t_wakeup();
        test_full();
        test_recovery();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
